riscv_trace_buf: RTL and testbench
==================================

Name: riscv_trace_buf

Overview:
- Synthesizable retirement trace buffer for the RISC-V pipeline; replaces ad-hoc clock/pc/instr printing with on-chip capture.
- Each captured entry is a cycle timestamp, the PC and the instruction of a retired instruction.
- Supports wrap (keep last DEPTH) and fill-once modes, an optional PC-match trigger with post-trigger count, and an in-order readout port.
- Sits beside the core and connects to its retire signals.

Parameters:
XLEN, 32, PC width
DEPTH, 16, entries; power of 2, at least 2
CNT_W, 32, cycle counter / timestamp width
POST_N, 4, retirements captured after the trigger entry (0 allowed)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-high (asserted = 1) despite the name
ret_valid  in  1  instruction retires this cycle
ret_pc  in  XLEN  retired PC
ret_instr  in  32  retired instruction
mode  in  1  0 = wrap, 1 = fill-once; sampled on arm
trig_en  in  1  enable PC trigger
trig_pc  in  XLEN  trigger PC
arm  in  1  one-cycle pulse: clear buffer, start capture
rd_en  in  1  pop oldest entry
rd_valid  out  1  rd_* data valid
rd_cycle  out  CNT_W  timestamp of popped entry
rd_pc  out  XLEN  PC of popped entry
rd_instr  out  32  instruction of popped entry
count  out  log2(DEPTH)+1  entries held
cycle_cnt  out  CNT_W  free-running cycle counter
state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
triggered  out  1  trigger has fired since last arm

Behaviour:
- Reset (async, rstn=1): state=IDLE, count=0, wptr=rptr=0, cycle_cnt=0, triggered=0, rd_valid=0, rd_* = 0, post counter=0, latched mode=0. Buffer RAM is not cleared.
- cycle_cnt: +1 every clock after reset; wraps modulo 2^CNT_W. Entry timestamp = cycle_cnt value during the retire cycle (pre-increment).
- arm: has priority over all other events in every state. Next state=CAPTURE; count=wptr=rptr=0; triggered=0; mode latched. A ret_valid in the same cycle as arm is not captured.
- CAPTURE, on ret_valid:
  - Write entry at wptr; wptr++ (mod DEPTH).
  - Not full: count++.
  - Full, latched mode 0: overwrite oldest; rptr++; count unchanged.
  - Full, latched mode 1: ret_valid ignored; state already DONE.
  - Mode 1: the write that makes count=DEPTH moves the state to DONE.
- Trigger: in CAPTURE, when trig_en and ret_valid and ret_pc==trig_pc, the entry is written, triggered=1 and post counter=POST_N. Next state=POST, or DONE if POST_N==0. Only the first match per arm fires.
- POST: each ret_valid writes an entry (same full rules) and decrements the post counter. On reaching 0, next state=DONE. In mode 1, full also forces DONE.
- DONE: no capture.
- rd_en in DONE with count>0: next cycle rd_valid=1, rd_* = entry[rptr]; rptr++; count--.
- rd_en when count==0, or in any state other than DONE: ignored; rd_valid=0 next cycle.
- rd_valid is a single-cycle pulse per accepted rd_en; rd_* hold their last value otherwise.
- Back-to-back rd_en is allowed: one entry per cycle.
- IDLE: only arm has effect.
- Reset mid-capture or mid-read: immediate return to reset values, no partial pop.

Test Plan:
- Reset mid-capture: arm, 3 retires, assert rstn -> same cycle state=0, count=0, cycle_cnt=0, rd_valid=0.
- Wrap + trigger (DEPTH=4, POST_N=2, mode=0, trig_pc=0x14): arm, then PCs 0x00..0x1C step 4 on consecutive cycles -> triggered=1 at 0x14, state POST then DONE after 0x1C. 4 reads return 0x10, 0x14, 0x18, 0x1C with consecutive timestamps; count goes 4→0.
- Fill-once (DEPTH=4, mode=1, trig_en=0): 6 retires 0x00..0x14 -> DONE after 0x0C, count=4. Reads return 0x00..0x0C; 0x10/0x14 are absent.
- Read gating: rd_en in CAPTURE, and a 5th rd_en in DONE with count=0 -> rd_valid stays 0, count unchanged.
- POST_N=0: trigger on the first retire -> DONE the next cycle, count=1, rd_pc=trig_pc.
- Timestamps and re-arm: retires with 0, 2 and 5 idle cycles between them -> timestamp deltas 1, 3, 6. arm in DONE -> count=0, triggered=0, state=1.

Source files
------------

// File: rtl/riscv_trace_buf.sv
// Retirement trace buffer: captures {timestamp, pc, instr} per retire, wrap or fill-once, PC trigger.
// Latency: entry written the cycle after retire; rd_* valid one cycle after an accepted rd_en.
// Backpressure: none on retire (full fill-once drops); rd_en outside DONE or when empty is ignored.
module riscv_trace_buf #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  parameter int POST_N = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       ret_valid,
  input  logic [XLEN-1:0]            ret_pc,
  input  logic [31:0]                ret_instr,
  input  logic                       mode,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       arm,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [CNT_W-1:0]           rd_cycle,
  output logic [XLEN-1:0]            rd_pc,
  output logic [31:0]                rd_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [1:0]                 state,
  output logic                       triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(POST_N + 2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [31:0]      instr;
  } entry_t;

  entry_t          mem [DEPTH];
  state_t          st_q, st_d;
  logic [AW-1:0]   wptr, rptr;
  logic [PW-1:0]   post_q, post_d;
  logic            mode_q;
  logic            full, cap_ok, trig_hit, rd_ok;

  assign state    = st_q;
  assign full     = (count == FULL);
  // A full fill-once buffer drops retires; arm always wins over capture and read.
  assign cap_ok   = (st_q == CAPTURE || st_q == POST) && ret_valid && !arm && !(mode_q && full);
  assign trig_hit = cap_ok && (st_q == CAPTURE) && trig_en && (ret_pc == trig_pc);
  assign rd_ok    = (st_q == DONE) && rd_en && !arm && (count != '0);

  always_comb begin
    st_d   = st_q;
    post_d = post_q;
    if (arm) begin
      st_d = CAPTURE;
    end else if (cap_ok) begin
      if (trig_hit) begin
        post_d = PW'(POST_N);
        st_d   = (POST_N == 0) ? DONE : POST;
      end else if (st_q == POST) begin
        post_d = post_q - 1'b1;
        if (post_q == PW'(1)) st_d = DONE;
      end
      if (mode_q && count == FULL - 1'b1) st_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      st_q      <= IDLE;
      post_q    <= '0;
      mode_q    <= 1'b0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      cycle_cnt <= '0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
      rd_cycle  <= '0;
      rd_pc     <= '0;
      rd_instr  <= '0;
    end else begin
      st_q      <= st_d;
      post_q    <= post_d;
      cycle_cnt <= cycle_cnt + 1'b1;
      rd_valid  <= 1'b0;
      if (arm) begin
        count     <= '0;
        wptr      <= '0;
        rptr      <= '0;
        triggered <= 1'b0;
        mode_q    <= mode;
      end else begin
        if (cap_ok) begin
          wptr <= wptr + 1'b1;
          // Wrap mode overwrites the oldest entry once full.
          if (!full) count <= count + 1'b1;
          else       rptr  <= rptr + 1'b1;
          if (trig_hit) triggered <= 1'b1;
        end
        if (rd_ok) begin
          rd_valid <= 1'b1;
          rd_cycle <= mem[rptr].cyc;
          rd_pc    <= mem[rptr].pc;
          rd_instr <= mem[rptr].instr;
          rptr     <= rptr + 1'b1;
          count    <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ok) mem[wptr] <= '{cyc: cycle_cnt, pc: ret_pc, instr: ret_instr};
  end

endmodule

// File: tb/tb_riscv_trace_buf.sv
// Bench for riscv_trace_buf: queue-based reference model checked every cycle, plus directed literal checks.
module tb_riscv_trace_buf;
  localparam int D  = 4;
  localparam int PN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_valid, mode, trig_en, arm, rd_en;
  logic [31:0] ret_pc, ret_instr, trig_pc;

  logic        rd_valid, triggered;
  logic [31:0] rd_cycle, rd_pc, rd_instr, cycle_cnt;
  logic [2:0]  count;
  logic [1:0]  state;

  logic        d0_rd_valid, d0_triggered;
  logic [31:0] d0_rd_cycle, d0_rd_pc, d0_rd_instr, d0_cycle_cnt;
  logic [2:0]  d0_count;
  logic [1:0]  d0_state;

  always #5 clk = ~clk;

  riscv_trace_buf #(.XLEN(32), .DEPTH(D), .CNT_W(32), .POST_N(PN)) u_dut (
    .clk(clk), .rstn(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .count(count), .cycle_cnt(cycle_cnt), .state(state), .triggered(triggered));

  riscv_trace_buf #(.XLEN(32), .DEPTH(D), .CNT_W(32), .POST_N(0)) u_dut0 (
    .clk(clk), .rstn(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm), .rd_en(rd_en),
    .rd_valid(d0_rd_valid), .rd_cycle(d0_rd_cycle), .rd_pc(d0_rd_pc), .rd_instr(d0_rd_instr),
    .count(d0_count), .cycle_cnt(d0_cycle_cnt), .state(d0_state), .triggered(d0_triggered));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of entries, oldest at the front.
  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_rd = '{0, 0, 0};
  ent_t        e;
  logic [31:0] m_cyc = 0;
  int          m_state = 0;
  int          m_post = 0;
  bit          m_trig = 0, m_mode = 0, m_rdv = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_state = 0; m_trig = 0; m_mode = 0; m_post = 0; m_rdv = 0;
      m_rd = '{0, 0, 0};
      mq.delete();
    end else begin
      e.cyc = m_cyc; e.pc = ret_pc; e.instr = ret_instr;
      m_cyc = m_cyc + 1;
      m_rdv = 0;
      if (arm) begin
        mq.delete(); m_state = 1; m_trig = 0; m_mode = mode;
      end else if ((m_state == 1 || m_state == 2) && ret_valid && !(m_mode && mq.size() == D)) begin
        mq.push_back(e);
        if (mq.size() > D) void'(mq.pop_front());
        if (m_state == 1 && trig_en && ret_pc == trig_pc) begin
          m_trig = 1; m_post = PN; m_state = (PN == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        if (m_mode && mq.size() == D) m_state = 3;
      end else if (m_state == 3 && rd_en && mq.size() > 0) begin
        m_rdv = 1;
        m_rd = mq.pop_front();
      end
    end
  end

  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("state", state, m_state);
      chk("count", count, mq.size());
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("triggered", triggered, m_trig);
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_cycle", rd_cycle, m_rd.cyc);
      chk("rd_pc", rd_pc, m_rd.pc);
      chk("rd_instr", rd_instr, m_rd.instr);
    end
  end

  task automatic cyc(input logic rv, input logic [31:0] pc, input logic a, input logic re);
    ret_valid = rv; ret_pc = pc; ret_instr = $urandom; arm = a; rd_en = re;
    @(negedge clk);
  endtask

  logic [31:0] ts [4];
  logic [31:0] prev_ts;

  initial begin
    rst = 1'b1; ret_valid = 0; ret_pc = 0; ret_instr = 0; mode = 0; trig_en = 0; trig_pc = 0;
    arm = 0; rd_en = 0;
    repeat (2) @(negedge clk);
    chk("reset state", state, 0);
    chk("reset count", count, 0);
    chk("reset cycle_cnt", cycle_cnt, 0);
    chk("reset rd_valid", rd_valid, 0);
    started = 1;
    rst = 1'b0;

    // Reset mid-capture
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h100 + 4 * i, 0, 0);
    chk("pre-reset count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst state", state, 0);
    chk("midrst count", count, 0);
    chk("midrst cycle_cnt", cycle_cnt, 0);
    chk("midrst rd_valid", rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap + trigger at 0x14, POST_N=2
    mode = 0; trig_en = 1; trig_pc = 32'h14;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 4 * i, 0, 0);
      if (i == 4) chk("trig before 0x14", triggered, 0);
      if (i == 5) begin chk("trig at 0x14", triggered, 1); chk("state POST", state, 2); end
      if (i == 6) chk("state POST after 0x18", state, 2);
    end
    chk("wrap DONE", state, 3);
    chk("wrap count", count, 4);
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 1);
      chk("wrap rd_valid", rd_valid, 1);
      chk("wrap rd_pc", rd_pc, 32'h10 + 4 * j);
      chk("wrap count dec", count, 3 - j);
      if (j > 0) chk("wrap ts delta", rd_cycle - prev_ts, 1);
      prev_ts = rd_cycle;
    end
    cyc(0, 0, 0, 1);
    chk("empty rd_valid", rd_valid, 0);
    chk("empty count", count, 0);

    // Fill-once, trigger disabled, read gated in CAPTURE
    mode = 1; trig_en = 0;
    cyc(0, 0, 1, 0);
    cyc(1, 32'h0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("capture rd gated", rd_valid, 0);
    chk("capture rd count", count, 1);
    for (int i = 1; i < 6; i++) cyc(1, 4 * i, 0, 0);
    chk("fill DONE", state, 3);
    chk("fill count", count, 4);
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 1);
      chk("fill rd_pc", rd_pc, 4 * j);
    end
    cyc(0, 0, 0, 1);
    chk("fill 5th rd", rd_valid, 0);

    // POST_N=0 instance
    mode = 0; trig_en = 1; trig_pc = 32'h40;
    cyc(0, 0, 1, 0);
    cyc(1, 32'h40, 0, 0);
    chk("pn0 state", d0_state, 3);
    chk("pn0 count", d0_count, 1);
    chk("pn0 triggered", d0_triggered, 1);
    cyc(0, 0, 0, 1);
    chk("pn0 rd_valid", d0_rd_valid, 1);
    chk("pn0 rd_pc", d0_rd_pc, 32'h40);

    // Timestamp gaps; trigger on the filling write in fill-once
    mode = 1; trig_en = 1; trig_pc = 32'h2C;
    cyc(0, 0, 1, 0);
    cyc(1, 32'h20, 0, 0);
    cyc(1, 32'h24, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 32'h28, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 32'h2C, 0, 0);
    chk("ts DONE", state, 3);
    chk("ts triggered", triggered, 1);
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 1);
      ts[j] = rd_cycle;
    end
    chk("ts delta1", ts[1] - ts[0], 1);
    chk("ts delta2", ts[2] - ts[1], 3);
    chk("ts delta3", ts[3] - ts[2], 6);
    cyc(1, 32'h2C, 1, 1);
    chk("rearm count", count, 0);
    chk("rearm triggered", triggered, 0);
    chk("rearm state", state, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        mode    = $urandom_range(0, 1);
        trig_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) trig_pc = 4 * $urandom_range(0, 15);
        cyc($urandom_range(0, 1), 4 * $urandom_range(0, 15), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0));
      end
    end

    cyc(0, 0, 0, 0);
    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
